// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// mor1kx_wb_arbiter_marocchino
//   N-source write-back arbiter for the MAROCCHINO pipeline. Execution units
//   offer completed results with valid/ready. One unit is granted per cycle
//   into a single registered write-back stage. The grant is fixed priority
//   (unit 0 highest) or round-robin.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   pipeline_flush_i         kill the wb stage and block grants this cycle
//   wb_ack_i                 downstream consumed the wb stage
//   unit_*_i                 per-unit request bundle, unit k at slice k
//   unit_ready_o             one-hot grant (zero when nothing is granted)
//   wb_*_o                   registered write-back stage
//   wb_unit_o                index of the unit that produced the wb stage
module mor1kx_wb_arbiter_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_UNITS            = 4,
    parameter int UNIT_IDX_WIDTH       = 2,
    parameter int ARB_MODE             = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       pipeline_flush_i,
    input  logic                                       wb_ack_i,
    input  logic [NUM_UNITS-1:0]                       unit_valid_i,
    output logic [NUM_UNITS-1:0]                       unit_ready_o,
    input  logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0]  unit_result_i,
    input  logic [NUM_UNITS*OPTION_RF_ADDR_WIDTH-1:0]  unit_rfd_adr_i,
    input  logic [NUM_UNITS-1:0]                       unit_rf_wb_i,
    input  logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0]  unit_pc_i,
    input  logic [NUM_UNITS-1:0]                       unit_except_i,
    input  logic [NUM_UNITS-1:0]                       unit_flag_set_i,
    input  logic [NUM_UNITS-1:0]                       unit_flag_clear_i,
    output logic                                       wb_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]            wb_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]            wb_rfd_adr_o,
    output logic                                       wb_rf_wb_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]            wb_pc_o,
    output logic                                       wb_except_o,
    output logic                                       wb_flag_set_o,
    output logic                                       wb_flag_clear_o,
    output logic [UNIT_IDX_WIDTH-1:0]                  wb_unit_o
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int IW = UNIT_IDX_WIDTH;
    // One extra bit so ptr + offset can exceed NUM_UNITS-1 before wrapping.
    localparam int SW = UNIT_IDX_WIDTH + 1;

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  result;
        logic [AW-1:0] adr;
        logic          rf_wb;
        logic [W-1:0]  pc;
        logic          except;
        logic          flag_set;
        logic          flag_clear;
        logic [IW-1:0] unit;
    } wb_stage_t;

    wb_stage_t     wb_d, wb_q;
    logic [IW-1:0] rr_ptr_d, rr_ptr_q;

    // Per-unit views of the flattened buses.
    logic [W-1:0]  res_a [NUM_UNITS];
    logic [AW-1:0] adr_a [NUM_UNITS];
    logic [W-1:0]  pc_a  [NUM_UNITS];

    genvar k;
    generate
        for (k = 0; k < NUM_UNITS; k++) begin : g_unpack
            assign res_a[k] = unit_result_i[k*W +: W];
            assign adr_a[k] = unit_rfd_adr_i[k*AW +: AW];
            assign pc_a[k]  = unit_pc_i[k*W +: W];
        end
    endgenerate

    // Grant selection. Fixed mode scans from 0; round-robin scans from the
    // pointer and wraps. Only the winner's data is ever muxed, so X on a
    // non-requesting unit stays contained.
    logic          grant_en;
    logic          grant;
    logic          found;
    logic [IW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic [IW-1:0] scan_base;

    assign grant_en  = (~wb_q.valid | wb_ack_i) & ~pipeline_flush_i & rst;
    assign scan_base = (ARB_MODE == 1) ? rr_ptr_q : '0;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = {1'b0, scan_base} + SW'(i);
            if (cand >= SW'(NUM_UNITS)) begin
                cand = cand - SW'(NUM_UNITS);
            end
            if (!found && unit_valid_i[cand[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    assign grant = grant_en & found;

    always_comb begin
        unit_ready_o = '0;
        if (grant) begin
            unit_ready_o[grant_idx] = 1'b1;
        end
    end

    // Write-back stage next state. Flush beats grant and ack; a full stage
    // without ack simply holds (grant_en is low then).
    always_comb begin
        wb_d     = wb_q;
        rr_ptr_d = rr_ptr_q;
        if (pipeline_flush_i) begin
            wb_d.valid      = 1'b0;
            wb_d.rf_wb      = 1'b0;
            wb_d.except     = 1'b0;
            wb_d.flag_set   = 1'b0;
            wb_d.flag_clear = 1'b0;
        end else if (grant) begin
            wb_d.valid      = 1'b1;
            wb_d.result     = res_a[grant_idx];
            wb_d.adr        = adr_a[grant_idx];
            wb_d.pc         = pc_a[grant_idx];
            wb_d.except     = unit_except_i[grant_idx];
            wb_d.unit       = grant_idx;
            // r0 is hardwired zero: drop writes to it.
            wb_d.rf_wb      = unit_rf_wb_i[grant_idx] & ~unit_except_i[grant_idx]
                              & (adr_a[grant_idx] != '0);
            wb_d.flag_set   = unit_flag_set_i[grant_idx] & ~unit_except_i[grant_idx];
            // Set wins over a simultaneous clear.
            wb_d.flag_clear = unit_flag_clear_i[grant_idx] & ~unit_except_i[grant_idx]
                              & ~unit_flag_set_i[grant_idx];
            rr_ptr_d        = (grant_idx == IW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (wb_ack_i) begin
            wb_d.valid      = 1'b0;
            wb_d.rf_wb      = 1'b0;
            wb_d.except     = 1'b0;
            wb_d.flag_set   = 1'b0;
            wb_d.flag_clear = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            wb_q     <= wb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign wb_valid_o      = wb_q.valid;
    assign wb_result_o     = wb_q.result;
    assign wb_rfd_adr_o    = wb_q.adr;
    assign wb_rf_wb_o      = wb_q.rf_wb;
    assign wb_pc_o         = wb_q.pc;
    assign wb_except_o     = wb_q.except;
    assign wb_flag_set_o   = wb_q.flag_set;
    assign wb_flag_clear_o = wb_q.flag_clear;
    assign wb_unit_o       = wb_q.unit;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Directed bench: a fixed-priority and a round-robin instance share stimulus.
module tb_mor1kx_wb_arbiter_marocchino;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         ack;
    logic [3:0]   valid;
    logic [127:0] res;
    logic [19:0]  adr;
    logic [3:0]   rfwb;
    logic [127:0] pc;
    logic [3:0]   exc;
    logic [3:0]   fset;
    logic [3:0]   fclr;

    logic [3:0]   rdy_f, rdy_r;
    logic         val_f, val_r, rfw_f, rfw_r, exc_f, exc_r, fs_f, fs_r, fc_f, fc_r;
    logic [31:0]  res_f, res_r, pc_f, pc_r;
    logic [4:0]   adr_f, adr_r;
    logic [1:0]   unit_f, unit_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mor1kx_wb_arbiter_marocchino #(.ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .pipeline_flush_i(flush), .wb_ack_i(ack),
        .unit_valid_i(valid), .unit_ready_o(rdy_f), .unit_result_i(res),
        .unit_rfd_adr_i(adr), .unit_rf_wb_i(rfwb), .unit_pc_i(pc),
        .unit_except_i(exc), .unit_flag_set_i(fset), .unit_flag_clear_i(fclr),
        .wb_valid_o(val_f), .wb_result_o(res_f), .wb_rfd_adr_o(adr_f),
        .wb_rf_wb_o(rfw_f), .wb_pc_o(pc_f), .wb_except_o(exc_f),
        .wb_flag_set_o(fs_f), .wb_flag_clear_o(fc_f), .wb_unit_o(unit_f));

    mor1kx_wb_arbiter_marocchino #(.ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .pipeline_flush_i(flush), .wb_ack_i(ack),
        .unit_valid_i(valid), .unit_ready_o(rdy_r), .unit_result_i(res),
        .unit_rfd_adr_i(adr), .unit_rf_wb_i(rfwb), .unit_pc_i(pc),
        .unit_except_i(exc), .unit_flag_set_i(fset), .unit_flag_clear_i(fclr),
        .wb_valid_o(val_r), .wb_result_o(res_r), .wb_rfd_adr_o(adr_r),
        .wb_rf_wb_o(rfw_r), .wb_pc_o(pc_r), .wb_except_o(exc_r),
        .wb_flag_set_o(fs_r), .wb_flag_clear_o(fc_r), .wb_unit_o(unit_r));

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default per-unit payload: result 0x1000_000k, adr k+1, pc 0x2000_0000+4k.
    task automatic load_defaults();
        for (int k = 0; k < 4; k++) begin
            res[k*32 +: 32] = 32'h1000_0000 + 32'(k);
            adr[k*5 +: 5]   = 5'(k + 1);
            pc[k*32 +: 32]  = 32'h2000_0000 + 32'(4 * k);
        end
        rfwb = 4'b1111;
        exc  = 4'b0000;
        fset = 4'b0000;
        fclr = 4'b0000;
    endtask

    // Two reset cycles, then release with the given request pattern.
    task automatic do_reset(input logic [3:0] v, input logic a);
        rst = 1'b0; flush = 1'b0; ack = a; valid = v;
        load_defaults();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ack = 1'b1; valid = 4'b1111;
        load_defaults();
        tick();
        tick();
        n_checks++; if (val_f !== 1'b0 || val_r !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b want 0/0", val_f, val_r); end
        n_checks++; if (res_f !== 32'h0 || pc_f !== 32'h0 || adr_f !== 5'h0 || unit_f !== 2'd0) begin n_fail++; $display("FAIL reset_data got res=%h pc=%h adr=%0d unit=%0d want zeros", res_f, pc_f, adr_f, unit_f); end
        n_checks++; if ({rfw_f, exc_f, fs_f, fc_f} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {rfw_f, exc_f, fs_f, fc_f}); end
        n_checks++; if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b/%b want 0000/0000", rdy_f, rdy_r); end
        rst = 1'b1;
        ack = 1'b0;
        #1;
        n_checks++; if (rdy_f !== 4'b0001 || rdy_r !== 4'b0001) begin n_fail++; $display("FAIL release_grant got %b/%b want 0001/0001", rdy_f, rdy_r); end
        tick();
        n_checks++; if (val_f !== 1'b1 || unit_f !== 2'd0 || res_f !== 32'h1000_0000 || rfw_f !== 1'b1) begin n_fail++; $display("FAIL release_capture got v=%b u=%0d r=%h w=%b want 1 0 10000000 1", val_f, unit_f, res_f, rfw_f); end
        n_checks++; if (val_r !== 1'b1 || unit_r !== 2'd0 || pc_r !== 32'h2000_0000) begin n_fail++; $display("FAIL release_capture_rr got v=%b u=%0d pc=%h want 1 0 20000000", val_r, unit_r, pc_r); end
        n_checks++; if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin n_fail++; $display("FAIL full_no_ack_ready got %b/%b want 0000/0000", rdy_f, rdy_r); end
    endtask

    task automatic test_fixed_priority();
        do_reset(4'b1010, 1'b1);
        n_checks++; if (rdy_f !== 4'b0010) begin n_fail++; $display("FAIL fixed_first_ready got %b want 0010", rdy_f); end
        tick();
        n_checks++; if (val_f !== 1'b1 || unit_f !== 2'd1 || res_f !== 32'h1000_0001 || adr_f !== 5'd2) begin n_fail++; $display("FAIL fixed_first_capture got v=%b u=%0d r=%h a=%0d want 1 1 10000001 2", val_f, unit_f, res_f, adr_f); end
        valid = 4'b1000;
        #1;
        n_checks++; if (rdy_f !== 4'b1000) begin n_fail++; $display("FAIL fixed_second_ready got %b want 1000", rdy_f); end
        tick();
        n_checks++; if (val_f !== 1'b1 || unit_f !== 2'd3 || pc_f !== 32'h2000_000C) begin n_fail++; $display("FAIL fixed_second_capture got v=%b u=%0d pc=%h want 1 3 2000000c", val_f, unit_f, pc_f); end
        valid = 4'b0000;
        tick();
        n_checks++; if (val_f !== 1'b0 || rfw_f !== 1'b0 || unit_f !== 2'd3 || res_f !== 32'h1000_0003) begin n_fail++; $display("FAIL ack_drain got v=%b w=%b u=%0d r=%h want 0 0 3 10000003", val_f, rfw_f, unit_f, res_f); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        do_reset(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rdy_r !== (4'b0001 << order[i])) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", i, rdy_r, 4'b0001 << order[i]); end
            n_checks++; if (rdy_f !== 4'b0001) begin n_fail++; $display("FAIL fixed_all_valid_ready[%0d] got %b want 0001", i, rdy_f); end
            tick();
            n_checks++; if (val_r !== 1'b1 || unit_r !== order[i] || res_r !== 32'h1000_0000 + 32'(order[i])) begin n_fail++; $display("FAIL rr_capture[%0d] got v=%b u=%0d r=%h want 1 %0d", i, val_r, unit_r, res_r, order[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset(4'b0100, 1'b0);
        n_checks++; if (rdy_f !== 4'b0100) begin n_fail++; $display("FAIL stall_first_ready got %b want 0100", rdy_f); end
        tick();
        res[2*32 +: 32] = 32'h5555_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d] got %b/%b want 0000/0000", i, rdy_f, rdy_r); end
            tick();
            n_checks++; if (val_f !== 1'b1 || res_f !== 32'h1000_0002 || unit_f !== 2'd2 || rfw_f !== 1'b1) begin n_fail++; $display("FAIL stall_frozen[%0d] got v=%b r=%h u=%0d w=%b want 1 10000002 2 1", i, val_f, res_f, unit_f, rfw_f); end
        end
        ack = 1'b1;
        #1;
        n_checks++; if (rdy_f !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ready got %b want 0100", rdy_f); end
        tick();
        n_checks++; if (val_f !== 1'b1 || res_f !== 32'h5555_0002) begin n_fail++; $display("FAIL stall_release_capture got v=%b r=%h want 1 55550002", val_f, res_f); end
    endtask

    task automatic test_qualification();
        do_reset(4'b0001, 1'b1);
        res[31:0] = 32'hDEAD_BEEF; adr[4:0] = 5'd5; exc[0] = 1'b1; fset[0] = 1'b1;
        tick();
        n_checks++; if (res_f !== 32'hDEAD_BEEF || rfw_f !== 1'b0 || exc_f !== 1'b1 || fs_f !== 1'b0 || adr_f !== 5'd5) begin n_fail++; $display("FAIL qual_except got r=%h w=%b e=%b fs=%b a=%0d want deadbeef 0 1 0 5", res_f, rfw_f, exc_f, fs_f, adr_f); end
        adr[4:0] = 5'd0; exc[0] = 1'b0; fset[0] = 1'b0;
        tick();
        n_checks++; if (val_f !== 1'b1 || rfw_f !== 1'b0 || exc_f !== 1'b0) begin n_fail++; $display("FAIL qual_r0 got v=%b w=%b e=%b want 1 0 0", val_f, rfw_f, exc_f); end
        adr[4:0] = 5'd7; fset[0] = 1'b1; fclr[0] = 1'b1;
        tick();
        n_checks++; if (rfw_f !== 1'b1 || fs_f !== 1'b1 || fc_f !== 1'b0) begin n_fail++; $display("FAIL qual_set_wins got w=%b fs=%b fc=%b want 1 1 0", rfw_f, fs_f, fc_f); end
        fset[0] = 1'b0;
        tick();
        n_checks++; if (fs_f !== 1'b0 || fc_f !== 1'b1) begin n_fail++; $display("FAIL qual_clear got fs=%b fc=%b want 0 1", fs_f, fc_f); end
        valid = 4'b0000;
        tick();
        n_checks++; if (val_f !== 1'b0 || fc_f !== 1'b0 || rfw_f !== 1'b0 || adr_f !== 5'd7) begin n_fail++; $display("FAIL qual_drain got v=%b fc=%b w=%b a=%0d want 0 0 0 7", val_f, fc_f, rfw_f, adr_f); end
    endtask

    task automatic test_flush();
        do_reset(4'b0001, 1'b1);
        tick();
        n_checks++; if (val_r !== 1'b1 || unit_r !== 2'd0) begin n_fail++; $display("FAIL flush_setup got v=%b u=%0d want 1 0", val_r, unit_r); end
        valid = 4'b0010; flush = 1'b1;
        #1;
        n_checks++; if (rdy_r !== 4'b0000 || rdy_f !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got %b/%b want 0000/0000", rdy_r, rdy_f); end
        tick();
        n_checks++; if (val_r !== 1'b0 || rfw_r !== 1'b0 || exc_r !== 1'b0 || unit_r !== 2'd0) begin n_fail++; $display("FAIL flush_kill got v=%b w=%b e=%b u=%0d want 0 0 0 0", val_r, rfw_r, exc_r, unit_r); end
        flush = 1'b0; valid = 4'b1111;
        #1;
        n_checks++; if (rdy_r !== 4'b0010 || rdy_f !== 4'b0001) begin n_fail++; $display("FAIL flush_ptr_kept got %b/%b want 0010/0001", rdy_r, rdy_f); end
        tick();
        n_checks++; if (val_r !== 1'b1 || unit_r !== 2'd1) begin n_fail++; $display("FAIL flush_resume got v=%b u=%0d want 1 1", val_r, unit_r); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ack = 1'b0; valid = 4'b0000;
        load_defaults();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_stall();
        test_qualification();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
